// File: rtl/axi4_mem_slave_ctrl_if.sv
//----------------------------------------------------------------------------
// axi4_mem_slave_ctrl_if
//
// AXI4 bundle of the five channels used by axi4_mem_slave_ctrl. Only the
// signals this slave needs are carried: no AWSIZE/AWBURST/ARSIZE/ARBURST,
// because every burst is treated as full-width INCR.
//
// Parameters
//   DATA_WIDTH      AXI data width
//   AXI_ADDR_WIDTH  AXI byte-address width
//   ID_WIDTH        AXI transaction ID width
//
// Modports
//   master  interconnect side: drives addresses, write data and ready for B/R
//   slave   memory controller side: drives AW/AR/W ready and the B/R channels
//----------------------------------------------------------------------------
interface axi4_mem_slave_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int ID_WIDTH       = 4
);

  // Write-address channel
  logic [ID_WIDTH-1:0]       AWID;
  logic [AXI_ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]                AWLEN;
  logic                      AWVALID;
  logic                      AWREADY;

  // Write-data channel
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WLAST;
  logic                      WVALID;
  logic                      WREADY;

  // Write-response channel
  logic [ID_WIDTH-1:0]       BID;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;

  // Read-address channel
  logic [ID_WIDTH-1:0]       ARID;
  logic [AXI_ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]                ARLEN;
  logic                      ARVALID;
  logic                      ARREADY;

  // Read-data channel
  logic [ID_WIDTH-1:0]       RID;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;
  logic                      RLAST;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi4_mem_slave_ctrl.sv
//----------------------------------------------------------------------------
// axi4_mem_slave_ctrl
//
// AXI4 slave protocol engine in front of a single-port word memory. Accepts
// one INCR burst at a time (writes win a same-cycle AW/AR tie), turns every
// beat into one memory-port access and returns registered read data on R.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   bus        AXI4 slave port (axi4_mem_slave_ctrl_if.slave)
//   mem_en     memory access strobe
//   mem_we     1 = write, 0 = read
//   mem_addr   memory word index (AXI byte address [ADDR_WIDTH+1:2])
//   mem_wdata  write word
//   mem_rdata  read word, valid the cycle after a read strobe, then held
//
// Build option
//   AXI_MEM_RANGE_CHECK_EN  when defined, a burst whose start index + LEN
//                           reaches DEPTH is answered with SLVERR and never
//                           touches the memory. When undefined the index
//                           wraps modulo 2**ADDR_WIDTH.
//----------------------------------------------------------------------------
module axi4_mem_slave_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int ID_WIDTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4_mem_slave_ctrl_if.slave  bus,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Parameter sanity: the word index must fit in the byte address, and the
  // memory cannot be deeper than the index can reach.
  if (AXI_ADDR_WIDTH < ADDR_WIDTH + 2) begin : g_bad_axi_addr_width
    $error("AXI_ADDR_WIDTH must be at least ADDR_WIDTH+2");
  end
  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must not exceed 2**ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_ISSUE,
    RD_DATA
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q,    id_d;     // ID of the burst in flight
  logic [ADDR_WIDTH-1:0] idx_q,   idx_d;    // word index of the current beat
  logic [7:0]            len_q,   len_d;    // AxLEN of the burst
  logic [7:0]            cnt_q,   cnt_d;    // beats completed so far
  logic                  oor_q,   oor_d;    // burst runs past the memory
  logic                  wlast_err_q, wlast_err_d;

  // Start word index of each request, straight from the byte address.
  logic [ADDR_WIDTH-1:0] aw_start, ar_start;
  assign aw_start = bus.AWADDR[ADDR_WIDTH+1:2];
  assign ar_start = bus.ARADDR[ADDR_WIDTH+1:2];

  // Out-of-range flag evaluated at the address handshake. 32-bit arithmetic
  // so start + LEN never overflows before the compare.
  logic aw_oor, ar_oor;
`ifdef AXI_MEM_RANGE_CHECK_EN
  assign aw_oor = (32'(aw_start) + 32'(bus.AWLEN)) >= 32'(DEPTH);
  assign ar_oor = (32'(ar_start) + 32'(bus.ARLEN)) >= 32'(DEPTH);
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Byte-lane bits, upper address bits and WSTRB are intentionally ignored:
  // every access is a full aligned word.
  logic unused_bits;
  assign unused_bits = ^{bus.AWADDR, bus.ARADDR, bus.WSTRB};

  logic last_beat;
  assign last_beat = (cnt_q == len_q);

  //--------------------------------------------------------------------------
  // Next state, datapath updates and all outputs
  //--------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    id_d        = id_q;
    idx_d       = idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    oor_d       = oor_q;
    wlast_err_d = wlast_err_q;

    bus.AWREADY = 1'b0;
    bus.ARREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    bus.BID     = '0;
    bus.BRESP   = RESP_OKAY;
    bus.RVALID  = 1'b0;
    bus.RID     = '0;
    bus.RDATA   = '0;
    bus.RRESP   = RESP_OKAY;
    bus.RLAST   = 1'b0;

    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    // While rst is high every output stays at its reset value, so a burst
    // interrupted by reset issues no further strobe even in the reset cycle.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          bus.AWREADY = 1'b1;
          bus.ARREADY = !bus.AWVALID;  // write wins a same-cycle tie
          if (bus.AWVALID) begin
            id_d        = bus.AWID;
            idx_d       = aw_start;
            len_d       = bus.AWLEN;
            cnt_d       = '0;
            oor_d       = aw_oor;
            wlast_err_d = 1'b0;
            state_d     = WR_DATA;
          end else if (bus.ARVALID) begin
            id_d        = bus.ARID;
            idx_d       = ar_start;
            len_d       = bus.ARLEN;
            cnt_d       = '0;
            oor_d       = ar_oor;
            wlast_err_d = 1'b0;
            state_d     = RD_ISSUE;
          end
        end

        WR_DATA: begin
          // Write data goes straight to the memory port, one beat per cycle.
          bus.WREADY = 1'b1;
          mem_en     = bus.WVALID && !oor_q;
          mem_we     = 1'b1;
          mem_addr   = idx_q;
          mem_wdata  = bus.WDATA;
          if (bus.WVALID) begin
            idx_d = idx_q + ADDR_WIDTH'(1);
            cnt_d = cnt_q + 8'd1;
            // The beat count, not WLAST, ends the burst; a misplaced WLAST
            // only turns the response into SLVERR.
            if (bus.WLAST != last_beat) begin
              wlast_err_d = 1'b1;
            end
            if (last_beat) begin
              state_d = WR_RESP;
            end
          end
        end

        WR_RESP: begin
          bus.BVALID = 1'b1;
          bus.BID    = id_q;
          bus.BRESP  = (oor_q || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
          if (bus.BREADY) begin
            state_d = IDLE;
          end
        end

        RD_ISSUE: begin
          mem_en   = !oor_q;
          mem_we   = 1'b0;
          mem_addr = idx_q;
          state_d  = RD_DATA;
        end

        RD_DATA: begin
          // No strobe here, so mem_rdata (and RDATA) holds under backpressure.
          bus.RVALID = 1'b1;
          bus.RID    = id_q;
          bus.RDATA  = oor_q ? '0 : mem_rdata;
          bus.RRESP  = oor_q ? RESP_SLVERR : RESP_OKAY;
          bus.RLAST  = last_beat;
          if (bus.RREADY) begin
            if (last_beat) begin
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + ADDR_WIDTH'(1);
              cnt_d   = cnt_q + 8'd1;
              state_d = RD_ISSUE;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // State and datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      oor_q       <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      oor_q       <= oor_d;
      wlast_err_q <= wlast_err_d;
    end
  end

endmodule

// File: tb/tb_axi4_mem_slave_ctrl.sv
//----------------------------------------------------------------------------
// tb_axi4_mem_slave_ctrl
//
// Self-checking bench for axi4_mem_slave_ctrl. A table of directed bursts is
// applied in a loop; reset, tie, mid-burst reset and index-wrap/range cases
// are hand-written sequences. A behavioural word memory answers the memory
// port and every strobe is logged for comparison.
// Build with +define+AXI_MEM_RANGE_CHECK_EN to exercise the range check.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_axi4_mem_slave_ctrl;

  localparam int DW      = 32;
  localparam int AW      = 10;
  localparam int DEPTH   = 1024;
  localparam int AAW     = 16;
  localparam int IW      = 4;
  localparam int TIMEOUT = 50;

`ifdef AXI_MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  axi4_mem_slave_ctrl_if #(.DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AAW), .ID_WIDTH(IW)) bus ();

  axi4_mem_slave_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .AXI_ADDR_WIDTH(AAW), .ID_WIDTH(IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with registered read data.
  logic [DW-1:0] tb_mem [DEPTH];
  logic          preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      tb_mem[1022] <= 32'h0000_00A1;
      tb_mem[1023] <= 32'h0000_00A2;
      tb_mem[0]    <= 32'h0000_00A3;
      tb_mem[1]    <= 32'h0000_00A4;
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata        <= tb_mem[mem_addr];
    end
  end

  // Strobe log, sampled mid-cycle.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } strobe_t;
  strobe_t st_q[$];
  always @(negedge clk) begin
    if (mem_en) st_q.push_back({mem_we, mem_addr, mem_wdata});
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } rbeat_t;
  rbeat_t rd_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [IW-1:0] id, input logic [AAW-1:0] addr,
                           input logic [7:0] len, input logic [DW-1:0] base,
                           input bit bad_wlast, output logic [1:0] resp,
                           output logic [IW-1:0] bid, output int b_lat);
    int n;
    int gaps;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.AWREADY && n < TIMEOUT) begin tick(); @(negedge clk); n++; end
    check("aw_ready", bus.AWREADY, 1);
    tick();
    bus.AWVALID = 1'b0;
    gaps = 0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.WVALID = 1'b1;
      bus.WDATA  = base + DW'(i);
      bus.WSTRB  = 4'(i);                       // ignored by the slave
      bus.WLAST  = (i == int'(len)) ^ bad_wlast;
      @(negedge clk);
      if (!bus.WREADY) gaps++;
      tick();
    end
    check("w_zero_bubble", gaps, 0);
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.BVALID && n < TIMEOUT) begin tick(); @(negedge clk); n++; end
    b_lat = n;
    resp  = bus.BRESP;
    bid   = bus.BID;
    tick();
    bus.BREADY = 1'b0;
  endtask

  // r_lat counts negedges without RVALID after the AR handshake edge; the
  // RD_ISSUE cycle makes it 1 (first RVALID two cycles after the handshake).
  task automatic axi_read(input logic [IW-1:0] id, input logic [AAW-1:0] addr,
                          input logic [7:0] len, input int stall,
                          input logic [DW-1:0] exp0, output int r_lat);
    int n;
    int bad;
    rd_q.delete();
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.ARREADY && n < TIMEOUT) begin tick(); @(negedge clk); n++; end
    check("ar_ready", bus.ARREADY, 1);
    tick();
    bus.ARVALID = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.RVALID && n < TIMEOUT) begin tick(); @(negedge clk); n++; end
    r_lat = n;
    for (int b = 0; b <= int'(len); b++) begin
      if (b > 0) begin
        n = 0;
        @(negedge clk);
        while (!bus.RVALID && n < TIMEOUT) begin tick(); @(negedge clk); n++; end
      end
      if (b == 0 && stall > 0) begin
        bad = 0;
        for (int k = 0; k < stall; k++) begin
          tick();
          @(negedge clk);
          if (!bus.RVALID || bus.RDATA !== exp0) bad++;
        end
        check("stall_hold", bad, 0);
        check("stall_strobes", st_q.size(), 1);
      end
      bus.RREADY = 1'b1;
      rd_q.push_back({bus.RDATA, bus.RRESP, bus.RLAST, bus.RID});
      tick();
      bus.RREADY = 1'b0;
    end
  endtask

  typedef struct {
    bit             is_wr;
    logic [IW-1:0]  id;
    logic [AAW-1:0] addr;
    logic [7:0]     len;
    logic [DW-1:0]  base;       // first data word; beat i carries base + i
    bit             bad_wlast;
    int             stall;      // RREADY-low cycles on the first read beat
    logic [1:0]     exp_resp;
    logic [AW-1:0]  exp_idx;    // expected first mem_addr
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [1:0]    resp;
    logic [IW-1:0] bid;
    int            lat;
    logic [AW-1:0] wrap_idx [4];
    logic [DW-1:0] wrap_dat [4];

    vecs[0] = '{1'b1, 4'h3, 16'h0010, 8'd0, 32'hDEAD_BEEF, 1'b0, 0, 2'b00, 10'd4};
    vecs[1] = '{1'b1, 4'h5, 16'h0100, 8'd3, 32'h0000_0001, 1'b0, 0, 2'b00, 10'd64};
    vecs[2] = '{1'b0, 4'h9, 16'h0100, 8'd3, 32'h0000_0001, 1'b0, 5, 2'b00, 10'd64};
    vecs[3] = '{1'b0, 4'h2, 16'h0010, 8'd0, 32'hDEAD_BEEF, 1'b0, 0, 2'b00, 10'd4};
    vecs[4] = '{1'b1, 4'h7, 16'h0200, 8'd1, 32'h0000_00A0, 1'b1, 0, 2'b10, 10'd128};
    vecs[5] = '{1'b0, 4'h1, 16'h0200, 8'd1, 32'h0000_00A0, 1'b0, 0, 2'b00, 10'd128};
    vecs[6] = '{1'b1, 4'hF, 16'h0FF0, 8'd1, 32'h0000_0055, 1'b0, 0, 2'b00, 10'd1020};
    vecs[7] = '{1'b0, 4'hE, 16'h0FF0, 8'd1, 32'h0000_0055, 1'b0, 2, 2'b00, 10'd1020};

    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    // ---- Reset state ----
    repeat (2) tick();
    @(negedge clk);
    check("reset_flags", {bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID,
                          bus.RVALID, bus.RLAST, mem_en, mem_we}, 0);
    check("reset_resp_ids", {bus.BRESP, bus.RRESP, bus.BID, bus.RID}, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_rdata", bus.RDATA, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", bus.AWREADY, 1);
    check("idle_arready", bus.ARREADY, 1);
    tick();

    // ---- Directed burst table ----
    for (int v = 0; v < NV; v++) begin
      st_q.delete();
      if (vecs[v].is_wr) begin
        axi_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].base,
                  vecs[v].bad_wlast, resp, bid, lat);
        check($sformatf("v%0d_bresp", v), resp, vecs[v].exp_resp);
        check($sformatf("v%0d_bid", v), bid, vecs[v].id);
        check($sformatf("v%0d_b_lat", v), lat, 0);
      end else begin
        axi_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].stall,
                 vecs[v].base, lat);
        check($sformatf("v%0d_r_lat", v), lat, 1);
        check($sformatf("v%0d_r_beats", v), rd_q.size(), int'(vecs[v].len) + 1);
        for (int i = 0; i < rd_q.size(); i++) begin
          check($sformatf("v%0d_rdata%0d", v, i), rd_q[i].data, vecs[v].base + DW'(i));
          check($sformatf("v%0d_rresp%0d", v, i), rd_q[i].resp, vecs[v].exp_resp);
          check($sformatf("v%0d_rlast%0d", v, i), rd_q[i].last, 32'(i == int'(vecs[v].len)));
          check($sformatf("v%0d_rid%0d", v, i), rd_q[i].id, vecs[v].id);
        end
      end
      check($sformatf("v%0d_strobes", v), st_q.size(), int'(vecs[v].len) + 1);
      for (int i = 0; i < st_q.size(); i++) begin
        check($sformatf("v%0d_saddr%0d", v, i), st_q[i].addr, vecs[v].exp_idx + AW'(i));
        check($sformatf("v%0d_swe%0d", v, i), st_q[i].we, vecs[v].is_wr);
        if (vecs[v].is_wr)
          check($sformatf("v%0d_sdata%0d", v, i), st_q[i].data, vecs[v].base + DW'(i));
      end
    end

    // ---- Tie: AW and AR in the same IDLE cycle, write served first ----
    st_q.delete();
    bus.AWID = 4'hA; bus.AWADDR = 16'h0300; bus.AWLEN = 8'd0; bus.AWVALID = 1'b1;
    bus.ARID = 4'hB; bus.ARADDR = 16'h0300; bus.ARLEN = 8'd0; bus.ARVALID = 1'b1;
    @(negedge clk);
    check("tie_awready", bus.AWREADY, 1);
    check("tie_arready", bus.ARREADY, 0);
    tick();
    bus.AWVALID = 1'b0;
    bus.WVALID = 1'b1; bus.WDATA = 32'hCAFE_F00D; bus.WLAST = 1'b1;
    @(negedge clk);
    check("tie_arready_wdata", bus.ARREADY, 0);
    tick();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b1;
    @(negedge clk);
    check("tie_bvalid", bus.BVALID, 1);
    check("tie_bid", bus.BID, 4'hA);
    check("tie_arready_bresp", bus.ARREADY, 0);
    tick();
    bus.BREADY = 1'b0;
    @(negedge clk);
    check("tie_arready_after_b", bus.ARREADY, 1);
    tick();
    bus.ARVALID = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.RVALID && lat < TIMEOUT) begin tick(); @(negedge clk); lat++; end
    check("tie_r_lat", lat, 1);
    check("tie_rdata", bus.RDATA, 32'hCAFE_F00D);
    check("tie_rid", bus.RID, 4'hB);
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check("tie_strobes", st_q.size(), 2);
    check("tie_order", {st_q[0].we, st_q[1].we}, 2'b10);

    // ---- Reset during beat 2 of an 8-beat write ----
    st_q.delete();
    bus.AWID = 4'h4; bus.AWADDR = 16'h0040; bus.AWLEN = 8'd7; bus.AWVALID = 1'b1;
    @(negedge clk);
    check("rst_seq_awready", bus.AWREADY, 1);
    tick();
    bus.AWVALID = 1'b0;
    bus.WVALID = 1'b1; bus.WDATA = 32'h0000_0100; bus.WLAST = 1'b0;
    tick();
    bus.WDATA = 32'h0000_0101;
    rst = 1'b1;
    @(negedge clk);
    check("rst_no_strobe", mem_en, 0);
    tick();
    bus.WVALID = 1'b0;
    @(negedge clk);
    check("rst_mid_flags", {bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID,
                            bus.RVALID, bus.RLAST, mem_en, mem_we}, 0);
    check("rst_mid_resp_ids", {bus.BRESP, bus.RRESP, bus.BID, bus.RID}, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    check("rst_mid_mem_wdata", mem_wdata, 0);
    check("rst_mid_strobes", st_q.size(), 1);
    tick();
    rst = 1'b0;
    st_q.delete();
    axi_write(4'h6, 16'h0044, 8'd0, 32'h5A5A_5A5A, 1'b0, resp, bid, lat);
    check("post_rst_bresp", resp, 2'b00);
    check("post_rst_bid", bid, 4'h6);
    check("post_rst_saddr", st_q[0].addr, 10'd17);
    axi_read(4'h3, 16'h0040, 8'd1, 0, 32'h0000_0100, lat);
    check("post_rst_rd0", rd_q[0].data, 32'h0000_0100);
    check("post_rst_rd1", rd_q[1].data, 32'h5A5A_5A5A);

    // ---- Index wrap / range check: read index 1022, LEN 3 ----
    preload = 1'b1;
    tick();
    preload = 1'b0;
    wrap_idx = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    wrap_dat = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    st_q.delete();
    axi_read(4'hC, 16'h0FF8, 8'd3, 0, 32'h0, lat);
    check("wrap_r_lat", lat, 1);
    check("wrap_r_beats", rd_q.size(), 4);
    check("wrap_strobes", st_q.size(), RC ? 0 : 4);
    for (int i = 0; i < rd_q.size(); i++) begin
      check($sformatf("wrap_rdata%0d", i), rd_q[i].data, RC ? 32'h0 : wrap_dat[i]);
      check($sformatf("wrap_rresp%0d", i), rd_q[i].resp, RC ? 2'b10 : 2'b00);
      check($sformatf("wrap_rlast%0d", i), rd_q[i].last, 32'(i == 3));
    end
    for (int i = 0; i < st_q.size(); i++)
      check($sformatf("wrap_saddr%0d", i), st_q[i].addr, wrap_idx[i]);

    // Write at index 1023, LEN 1: wraps to 0, or is rejected with SLVERR.
    st_q.delete();
    axi_write(4'hD, 16'h0FFC, 8'd1, 32'h0000_0077, 1'b0, resp, bid, lat);
    check("wrap_bresp", resp, RC ? 2'b10 : 2'b00);
    check("wrap_w_strobes", st_q.size(), RC ? 0 : 2);
    for (int i = 0; i < st_q.size(); i++)
      check($sformatf("wrap_w_saddr%0d", i), st_q[i].addr, wrap_idx[i + 1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_mem_slave_ctrl.md
# axi4_mem_slave_ctrl

AXI4 slave protocol engine that sits between the AXI4 interconnect and the single-port word memory. It accepts INCR write and read bursts, converts each beat into one memory-port access (`mem_en`/`mem_we`/`mem_addr`/`mem_wdata`), collects registered read data and returns it on the R channel. It handles one transaction at a time, with writes winning ties.

## Interface
- `DATA_WIDTH`, 32, AXI data width and memory word width.
- `ADDR_WIDTH`, 10, memory word-index width; memory depth is `DEPTH`.
- `DEPTH`, 1024, number of memory words.
- `AXI_ADDR_WIDTH`, 16, AXI byte-address width; must be ≥ `ADDR_WIDTH+2`.
- `ID_WIDTH`, 4, AXI ID width.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `AWID`/`AWADDR`/`AWLEN[7:0]`/`AWVALID`  in; `AWREADY`  out  write-address channel.
- `WDATA`/`WSTRB`/`WLAST`/`WVALID`  in; `WREADY`  out  write-data channel.
- `BID`/`BRESP[1:0]`/`BVALID`  out; `BREADY`  in  write-response channel.
- `ARID`/`ARADDR`/`ARLEN[7:0]`/`ARVALID`  in; `ARREADY`  out  read-address channel.
- `RID`/`RDATA`/`RRESP[1:0]`/`RLAST`/`RVALID`  out; `RREADY`  in  read-data channel.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  `ADDR_WIDTH`  word index = byte address `[ADDR_WIDTH+1:2]`.
- `mem_wdata`  out  `DATA_WIDTH`  write word.
- `mem_rdata`  in  `DATA_WIDTH`  read word; valid the cycle after a read strobe and held until the next read.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_DATA.
- **IDLE**
  - `AWREADY` = 1.
  - `ARREADY` = `!AWVALID`, so write wins a same-cycle tie.
- **Address handshake**
  - Latches ID, start index, LEN and beat counter = 0.
  - AW handshake goes to WR_DATA; AR handshake goes to RD_ISSUE.
- **Bursts**
  - All bursts are treated as INCR, full width (`AWSIZE`/`AWBURST` not decoded).
  - Index increments by 1 per beat and is `ADDR_WIDTH` bits wide.
- **WR_DATA**
  - `WREADY` = 1.
  - Each cycle: `mem_en` = `WVALID`, `mem_we` = 1, `mem_addr` = index, `mem_wdata` = `WDATA`.
  - `WSTRB` is ignored; every write is a full word.
  - Each beat increments index and counter.
  - The beat with counter == LEN ends the burst and goes to WR_RESP. `WLAST` does not terminate the burst.
  - If `WLAST` disagrees with the final-beat position, `BRESP` = SLVERR, but the writes still happen.
- **WR_RESP**
  - `BVALID` = 1 with `BID`/`BRESP` held stable.
  - `BREADY` returns the FSM to IDLE.
- **RD_ISSUE**
  - One cycle: `mem_en` = 1, `mem_we` = 0, `mem_addr` = index; then goes to RD_DATA.
- **RD_DATA**
  - `RVALID` = 1, `RDATA` = `mem_rdata`, `RID` = latched ID, `RRESP` = OKAY.
  - `RLAST` = 1 when counter == LEN.
  - On handshake: if last, go to IDLE; otherwise increment index and counter and go to RD_ISSUE.
- **Memory strobe:** `mem_en` = 0 in every state except as above.
- **Reset values**
  - All READY/VALID outputs, `mem_en` and `mem_we` = 0.
  - `BRESP`/`RRESP`/`RDATA`/`mem_addr`/`mem_wdata`/IDs = 0.
  - `RLAST` = 0; state = IDLE.
- **Reset mid-burst:** aborts immediately with no further memory strobes and no response issued.

## Timing
- Address handshake at edge T0 → FSM in WR_DATA/RD_ISSUE during cycle T0+1.
- **Write**
  - Zero-bubble: one beat per cycle while `WVALID`.
  - `BVALID` asserts the cycle after the last W handshake.
- **Read**
  - First `RVALID` arrives 2 cycles after the AR handshake.
  - Each beat takes ≥ 2 cycles (issue + data).
  - `RDATA` stays stable while `RVALID && !RREADY`, because no strobe is issued in RD_DATA.
- **Ready after response:** `AWREADY`/`ARREADY` reassert the cycle after a B or last-R handshake.
- **Index wrap:** the index wraps modulo 2^`ADDR_WIDTH` unless the range check below is enabled.

## Configuration
- **`AXI_MEM_RANGE_CHECK_EN` defined**
  - At address handshake, a burst whose start index + LEN ≥ `DEPTH` is flagged as an error.
  - Errored write: all beats are accepted with `mem_en` forced to 0, and `BRESP` = SLVERR (2'b10).
  - Errored read: RD_ISSUE asserts no `mem_en`; every beat returns `RDATA` = 0 and `RRESP` = SLVERR.
- **Undefined:** no check; the index wraps silently and the response is OKAY (except the `WLAST` mismatch case).

## Test plan
- Single write: AW addr 0x10, LEN 0, W 0xDEADBEEF with WLAST → one `mem_en`/`mem_we` with `mem_addr` 4; `BRESP` OKAY, `BID` echoes `AWID`.
- 4-beat write then 4-beat read at 0x100 with data 1..4 → `mem_addr` 64..67; R returns 1,2,3,4, `RLAST` only on beat 4, OKAY.
- Read backpressure: `RREADY` low 5 cycles on beat 1 → `RDATA`/`RVALID` stable, no extra `mem_en`, burst completes correctly.
- Tie: `AWVALID` and `ARVALID` rise in the same IDLE cycle → write burst served first, read accepted after the B handshake.
- Reset mid-burst: `rst` during beat 2 of an 8-beat write → next cycle all outputs are at reset values; a new AW is accepted afterwards.
- With `AXI_MEM_RANGE_CHECK_EN`: read at index 1022, LEN 3 → no `mem_en`; 4 beats of `RDATA` = 0, `RRESP` SLVERR. Without the macro, indices 1022, 1023, 0, 1 are read with OKAY.
